// File: rtl/bip_dump_tx.sv
// UART state dump: sends a 0xA5 header, the PC/ACC snapshot and DUMP_WORDS memory words as 8N1 bytes.
// Optional trailing XOR checksum byte is compiled in when BIP_DUMP_CHECKSUM_EN is defined.
module bip_dump_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DUMP_WORDS   = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [10:0] PC,
    input  logic [15:0] ACC,
    output logic [10:0] Mem_Addr,
    output logic        Mem_Rd,
    input  logic [15:0] Mem_Data,
    output logic        Tx,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {
        IDLE, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT, FINISH
    } state_t;

    localparam logic [15:0] LP_CPB_M1    = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] LP_CPB_M2    = 16'(CLKS_PER_BIT - 2);
    localparam logic [10:0] LP_LAST_WORD = 11'(DUMP_WORDS - 1);
    localparam logic [2:0]  LP_HDR_DONE  = 3'd5;

    state_t      r_state;
    logic [15:0] r_clk_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [15:0] r_pc;
    logic [15:0] r_acc;
    logic [2:0]  r_hdr_idx;
    logic [10:0] r_word;
    logic        r_half;
    logic [7:0]  r_mem_lo;
    logic        r_last;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;
    logic        r_mem_rd;
    logic [10:0] r_mem_addr;
    logic [7:0]  w_byte;
`ifdef BIP_DUMP_CHECKSUM_EN
    logic [7:0]  r_csum;
    logic        r_ck_phase;

    function automatic logic [7:0] f_csum_next(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction
`endif

    assign Tx       = r_tx;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Mem_Rd   = r_mem_rd;
    assign Mem_Addr = r_mem_addr;

    // Byte to be loaded in LOAD; the high memory byte comes straight off the read port.
    always_comb begin
        w_byte = 8'h00;
        if (r_hdr_idx != LP_HDR_DONE) begin
            case (r_hdr_idx)
                3'd0:    w_byte = 8'hA5;
                3'd1:    w_byte = r_pc[15:8];
                3'd2:    w_byte = r_pc[7:0];
                3'd3:    w_byte = r_acc[15:8];
                3'd4:    w_byte = r_acc[7:0];
                default: w_byte = 8'hA5;
            endcase
        end
`ifdef BIP_DUMP_CHECKSUM_EN
        else if (r_ck_phase) begin
            w_byte = r_csum;
        end
`endif
        else if (!r_half) begin
            w_byte = Mem_Data[15:8];
        end else begin
            w_byte = r_mem_lo;
        end
    end

    // Frame sequencer: LOAD is the first cycle of every start bit, NEXT the last cycle of every stop bit.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_clk_cnt  <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_pc       <= 16'h0000;
            r_acc      <= 16'h0000;
            r_hdr_idx  <= 3'd0;
            r_word     <= 11'd0;
            r_half     <= 1'b0;
            r_mem_lo   <= 8'h00;
            r_last     <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= 11'd0;
`ifdef BIP_DUMP_CHECKSUM_EN
            r_csum     <= 8'h00;
            r_ck_phase <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_pc      <= {5'd0, PC};
                        r_acc     <= ACC;
                        r_busy    <= 1'b1;
                        r_tx      <= 1'b0;
                        r_hdr_idx <= 3'd0;
                        r_word    <= 11'd0;
                        r_half    <= 1'b0;
                        r_last    <= 1'b0;
`ifdef BIP_DUMP_CHECKSUM_EN
                        r_csum     <= 8'h00;
                        r_ck_phase <= 1'b0;
`endif
                        r_state   <= LOAD;
                    end
                end
                LOAD: begin
                    r_shift    <= w_byte;
                    r_clk_cnt  <= 16'd1;
                    r_mem_rd   <= 1'b0;
                    r_mem_addr <= 11'd0;
                    if (r_mem_rd) begin
                        r_mem_lo <= Mem_Data[7:0];
                    end
`ifdef BIP_DUMP_CHECKSUM_EN
                    if (r_hdr_idx != 3'd0 && !r_ck_phase) begin
                        r_csum <= f_csum_next(r_csum, w_byte);
                    end
`endif
                    // Indices advance here so NEXT already knows what the following byte is.
                    if (r_hdr_idx != LP_HDR_DONE) begin
                        r_hdr_idx <= r_hdr_idx + 3'd1;
                    end
`ifdef BIP_DUMP_CHECKSUM_EN
                    else if (r_ck_phase) begin
                        r_last <= 1'b1;
                    end
`endif
                    else if (!r_half) begin
                        r_half <= 1'b1;
                    end else begin
                        r_half <= 1'b0;
                        if (r_word == LP_LAST_WORD) begin
`ifdef BIP_DUMP_CHECKSUM_EN
                            r_ck_phase <= 1'b1;
`else
                            r_last <= 1'b1;
`endif
                        end else begin
                            r_word <= r_word + 11'd1;
                        end
                    end
                    r_state <= START_BIT;
                end
                START_BIT: begin
                    if (r_clk_cnt == LP_CPB_M1) begin
                        r_clk_cnt <= 16'd0;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA_BITS;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                DATA_BITS: begin
                    if (r_clk_cnt == LP_CPB_M1) begin
                        r_clk_cnt <= 16'd0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP_BIT;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                STOP_BIT: begin
                    if (r_clk_cnt == LP_CPB_M2) begin
                        r_clk_cnt <= 16'd0;
                        r_state   <= NEXT;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                NEXT: begin
                    if (r_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FINISH;
                    end else begin
                        r_tx    <= 1'b0;
                        r_state <= LOAD;
`ifdef BIP_DUMP_CHECKSUM_EN
                        if (r_hdr_idx == LP_HDR_DONE && !r_half && !r_ck_phase) begin
`else
                        if (r_hdr_idx == LP_HDR_DONE && !r_half) begin
`endif
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= r_word;
                        end
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bip_dump_tx.md
BIP_DUMP_TX -- requirements
Module: bip_dump_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per UART bit, legal range 2..65535.
REQ-002 Parameter DUMP_WORDS, default 16: number of data-memory words dumped, starting at address 0, legal range 1..2048.
REQ-003 Port Clk  input  1: single clock; all state changes on rising edge.
REQ-004 Port Reset  input  1: synchronous, active-high reset.
REQ-005 Port Start  input  1: dump request, sampled only in IDLE.
REQ-006 Port PC  input  11: processor program counter, snapshotted on accepted Start.
REQ-007 Port ACC  input  16: processor accumulator, snapshotted on accepted Start.
REQ-008 Port Mem_Addr  output  11: data-memory read address.
REQ-009 Port Mem_Rd  output  1: data-memory read strobe.
REQ-010 Port Mem_Data  input  16: data-memory read data, combinational from Mem_Addr/Mem_Rd.
REQ-011 Port Tx  output  1: UART serial out, 8N1, LSB first, idle high.
REQ-012 Port Busy  output  1: high while a frame is in progress.
REQ-013 Port Done  output  1: one-cycle pulse at frame end.

Function
REQ-014 States SHALL be IDLE, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT, FINISH.
REQ-015 IDLE with Start=1 SHALL snapshot PC (zero-extended to 16 bits) and ACC, set Busy=1 next edge, and go to LOAD.
REQ-016 Start while Busy=1 SHALL be ignored; no queuing.
REQ-017 Frame byte order: 0xA5 header, PC[15:8], PC[7:0], ACC[15:8], ACC[7:0], then for word n = 0..DUMP_WORDS-1: mem[n][15:8], mem[n][7:0].
REQ-018 Memory word n SHALL be read once: Mem_Addr=n and Mem_Rd=1 for exactly one cycle in LOAD before its high byte; Mem_Data is captured in that same cycle. Mem_Rd=0 and Mem_Addr=0 otherwise.
REQ-019 Each bit SHALL last exactly CLKS_PER_BIT cycles; a byte is 10 bits (start 0, 8 data LSB first, stop 1).
REQ-020 Consecutive bytes SHALL be back-to-back, with no idle bits between a stop bit and the next start bit.
REQ-021 Tx SHALL fall on the edge after Start is accepted; LOAD SHALL overlap the start bit, not delay it.
REQ-022 Frame time SHALL be (5 + 2*DUMP_WORDS + C) * 10 * CLKS_PER_BIT cycles from first Tx fall to end of the last stop bit, where C=1 with the checksum compiled in and C=0 without.
REQ-023 After the last stop bit, FINISH SHALL drive Done=1 for one cycle with Busy=0 and Tx=1, then return to IDLE; a Start in the FINISH cycle is ignored.
REQ-024 The word counter SHALL be 11 bits; DUMP_WORDS=2048 SHALL end at address 2047 without wrap to 0.
REQ-025 Changes on PC/ACC during a frame SHALL not affect the transmitted bytes.

Reset
REQ-026 Reset=1 at any edge, including mid-frame, SHALL force state IDLE, Tx=1, Busy=0, Done=0, Mem_Rd=0, Mem_Addr=0, and clear all counters and snapshots.
REQ-027 Reset SHALL take priority over Start in the same cycle.

Configuration
REQ-028 Macro BIP_DUMP_CHECKSUM_EN defined: one extra byte SHALL follow the last word, equal to the XOR of all frame bytes except the 0xA5 header.
REQ-029 Macro BIP_DUMP_CHECKSUM_EN undefined: the frame SHALL end after mem[DUMP_WORDS-1][7:0], and no checksum logic SHALL be present.

Verification
REQ-030 CLKS_PER_BIT=4, DUMP_WORDS=2, mem[0]=0x1234, mem[1]=0xFFFF, PC=0x005, ACC=0x8001, macro off, Start pulse -> bytes A5 00 05 80 01 12 34 FF FF; Done 360 cycles after the first Tx fall.
REQ-031 Same stimulus with the macro on -> the same bytes followed by 0xA2; Done 400 cycles after the first Tx fall.
REQ-032 Start pulses every 10 cycles during a frame -> exactly one frame is sent; Busy stays high until FINISH.
REQ-033 Reset asserted at cycle 50 of a frame -> the next edge gives Tx=1, Busy=0, Mem_Rd=0; a new Start yields a complete, correct frame.
REQ-034 Verify Mem_Rd across one frame -> exactly DUMP_WORDS one-cycle pulses with Mem_Addr 0,1,... in order.
REQ-035 PC=0x7FF, ACC=0xFFFF, with PC/ACC changed on the edge after Start -> transmitted bytes are 07 FF FF FF.
